// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : Pipe_Buf_Reg_PKG (package)
// Description : Pipeline buffer structs for the 5-stage RISC-V core, plus the
//               hazard-unit FSM state enum and forward-select encodings.
//               The helper function fwd_sel() picks one operand's forwarding
//               source. The EX/MEM stage has priority over MEM/WB.
// Revision    : 1.0 - initial release
// ============================================================================
package Pipe_Buf_Reg_PKG;

    typedef struct packed {
        logic [31:0] Curr_Pc;
        logic [31:0] Curr_Instr;
    } if_id_reg;

    typedef struct packed {
        logic [31:0] Curr_Pc;
        logic [31:0] RD_One;
        logic [31:0] RD_Two;
        logic [31:0] Immediate;
        logic [4:0]  RS_One;
        logic [4:0]  RS_Two;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic        MemToReg;
        logic        HaltSignal;
    } id_ex_reg;

    typedef struct packed {
        logic [31:0] Alu_Result;
        logic [31:0] RD_Two;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic        MemToReg;
    } ex_mem_reg;

    typedef struct packed {
        logic [31:0] Alu_Result;
        logic [31:0] Mem_Data;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemToReg;
    } mem_wb_reg;

    // Hazard-unit halt-drain state machine
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file read (RD_One/RD_Two)
    localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB writeback value
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM Alu_Result

    // Forward from the youngest producer that writes a non-zero register
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            return FWD_MEM;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fwd_unit
// Description : Purely combinational EX-stage operand forwarding selects.
// Ports       : id_ex_rs1/id_ex_rs2 - EX-stage source registers
//               ex_mem_we/ex_mem_rd - EX/MEM producer write enable / dest
//               mem_wb_we/mem_wb_rd - MEM/WB producer write enable / dest
//               fwd_a/fwd_b         - operand A/B source select (FWD_*)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fwd_unit
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic [4:0] id_ex_rs1,
    input  logic [4:0] id_ex_rs2,
    input  logic       ex_mem_we,
    input  logic [4:0] ex_mem_rd,
    input  logic       mem_wb_we,
    input  logic [4:0] mem_wb_rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    assign fwd_a = fwd_sel(id_ex_rs1, ex_mem_we, ex_mem_rd, mem_wb_we, mem_wb_rd);
    assign fwd_b = fwd_sel(id_ex_rs2, ex_mem_we, ex_mem_rd, mem_wb_we, mem_wb_rd);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline hazard/control unit. Drives stall, flush and
//               forwarding controls from the four pipeline buffers and runs
//               the halt-drain FSM (RUN -> DRAIN -> HALTED).
//               Optional feature macro: HAZARD_PERF_CNT_EN builds the
//               saturating stall/flush counters; otherwise they read 0.
// Ports       : clk, rst_n (async, active-low)
//               if_id/id_ex/ex_mem/mem_wb - current buffer contents
//               branch_taken              - EX redirect this cycle
//               pc_en, if_id_en           - PC / IF-ID write enables
//               if_id_flush, id_ex_flush  - bubble loads
//               fwd_a, fwd_b              - EX operand selects
//               halted                    - core drained after halt
//               stall_cnt, flush_cnt      - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  if_id_reg         if_id,
    input  id_ex_reg         id_ex,
    input  ex_mem_reg        ex_mem,
    input  mem_wb_reg        mem_wb,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int c_DRAIN_W = ($clog2(DRAIN_CYCLES + 1) < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES);

    hz_state_e            r_state;
    hz_state_e            w_state_nxt;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic [c_DRAIN_W-1:0] w_drain_nxt;

    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_load_use;

    // Most buffer fields belong to the datapath; fold them together so the
    // whole structs count as consumed.
    logic w_unused_bufs;
    assign w_unused_bufs = ^{if_id, id_ex, ex_mem, mem_wb};

    // ID-stage sources are compared regardless of opcode: a spurious stall on
    // an instruction without rs2 costs one cycle but is never incorrect.
    assign w_rs1      = if_id.Curr_Instr[19:15];
    assign w_rs2      = if_id.Curr_Instr[24:20];
    assign w_load_use = id_ex.MemRead && (id_ex.rd != 5'd0) &&
                        ((id_ex.rd == w_rs1) || (id_ex.rd == w_rs2));

    pipe_fwd_unit u_fwd (
        .id_ex_rs1 (id_ex.RS_One),
        .id_ex_rs2 (id_ex.RS_Two),
        .ex_mem_we (ex_mem.RegWrite),
        .ex_mem_rd (ex_mem.rd),
        .mem_wb_we (mem_wb.RegWrite),
        .mem_wb_rd (mem_wb.rd),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        case (r_state)
            RUN: begin
                if (id_ex.HaltSignal) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    w_state_nxt = DRAIN;
                    w_drain_nxt = c_DRAIN_LOAD;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            DRAIN: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                w_drain_nxt = r_drain_cnt - c_DRAIN_W'(1);
                // <= also covers a zero-length drain configuration
                if (r_drain_cnt <= c_DRAIN_W'(1)) begin
                    w_state_nxt = HALTED;
                end
            end
            default: begin
                // HALTED (and any unreachable encoding) keeps the core frozen
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
        endcase
    end

    assign halted = (r_state == HALTED);

`ifdef HAZARD_PERF_CNT_EN
    logic             w_stall_win;
    logic             w_flush_win;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Count only the row that actually won the RUN priority decode
    assign w_flush_win = (r_state == RUN) && !id_ex.HaltSignal && branch_taken;
    assign w_stall_win = (r_state == RUN) && !id_ex.HaltSignal && !branch_taken && w_load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_win && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_win && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Directed steps for
//               load-use, forwarding priority, branch priority, halt drain,
//               reset mid-drain and counter saturation, followed by random
//               segments, all checked against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    import Pipe_Buf_Reg_PKG::*;

    localparam int CW = 4;
    localparam int DC = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    if_id_reg      if_id;
    id_ex_reg      id_ex;
    ex_mem_reg     ex_mem;
    mem_wb_reg     mem_wb;
    logic          branch_taken;
    logic          pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_id        (if_id),
        .id_ex        (id_ex),
        .ex_mem       (ex_mem),
        .mem_wb       (mem_wb),
        .branch_taken (branch_taken),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: edges seen since the halt left EX (-1 = none),
    // and the ideal (saturating) event counts.
    int m_since;
    int m_stall;
    int m_flush;

    function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, 5'd1, 7'b0110011};
    endfunction

    function automatic bit model_lu();
        int r1, r2;
        r1 = int'(if_id.Curr_Instr[19:15]);
        r2 = int'(if_id.Curr_Instr[24:20]);
        return id_ex.MemRead && (id_ex.rd != 0) && ((int'(id_ex.rd) == r1) || (int'(id_ex.rd) == r2));
    endfunction

    // 2 = EX/MEM, 1 = MEM/WB, 0 = register file
    function automatic int model_fwd(input int rs);
        if (ex_mem.RegWrite && ex_mem.rd != 0 && int'(ex_mem.rd) == rs) return 2;
        if (mem_wb.RegWrite && mem_wb.rd != 0 && int'(mem_wb.rd) == rs) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit frozen, lu;
        int es, ef;
        frozen = (m_since >= 0) || id_ex.HaltSignal;
        lu     = model_lu();
        if (frozen) begin
            chk("pc_en_frz", 32'(pc_en), 32'd0);
            chk("if_id_en_frz", 32'(if_id_en), 32'd0);
            chk("if_id_flush_frz", 32'(if_id_flush), 32'd1);
            chk("id_ex_flush_frz", 32'(id_ex_flush), 32'd1);
        end else if (branch_taken) begin
            chk("pc_en_br", 32'(pc_en), 32'd1);
            chk("if_id_flush_br", 32'(if_id_flush), 32'd1);
            chk("id_ex_flush_br", 32'(id_ex_flush), 32'd1);
        end else if (lu) begin
            chk("pc_en_lu", 32'(pc_en), 32'd0);
            chk("if_id_en_lu", 32'(if_id_en), 32'd0);
            chk("if_id_flush_lu", 32'(if_id_flush), 32'd0);
            chk("id_ex_flush_lu", 32'(id_ex_flush), 32'd1);
        end else begin
            chk("pc_en_run", 32'(pc_en), 32'd1);
            chk("if_id_en_run", 32'(if_id_en), 32'd1);
            chk("if_id_flush_run", 32'(if_id_flush), 32'd0);
            chk("id_ex_flush_run", 32'(id_ex_flush), 32'd0);
        end
        chk("fwd_a", 32'(fwd_a), 32'(model_fwd(int'(id_ex.RS_One))));
        chk("fwd_b", 32'(fwd_b), 32'(model_fwd(int'(id_ex.RS_Two))));
        chk("halted", 32'(halted), 32'(m_since >= DC + 1));
`ifdef HAZARD_PERF_CNT_EN
        es = m_stall;
        ef = m_flush;
`else
        es = 0;
        ef = 0;
`endif
        chk("stall_cnt", 32'(stall_cnt), 32'(es));
        chk("flush_cnt", 32'(flush_cnt), 32'(ef));
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic update_model();
        if (rst_n) begin
            if (m_since >= 0) begin
                if (m_since < 1000) m_since++;
            end else if (id_ex.HaltSignal) begin
                m_since = 1;
            end else if (branch_taken) begin
                m_flush = (m_flush + 1 > SAT) ? SAT : m_flush + 1;
            end else if (model_lu()) begin
                m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
            end
        end
    endtask

    // Inputs are set at posedge+2; checks happen at posedge+3
    task automatic step();
        #1;
        check_all();
        update_model();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        if_id        = '0;
        id_ex        = '0;
        ex_mem       = '0;
        mem_wb       = '0;
        branch_taken = 1'b0;
    endtask

    // Asynchronous reset asserted away from the clock edge, checked at once
    task automatic do_reset();
        rst_n   = 1'b0;
        m_since = -1;
        m_stall = 0;
        m_flush = 0;
        #1;
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        if_id.Curr_Pc       = $urandom;
        if_id.Curr_Instr    = $urandom;
        if_id.Curr_Instr[19:15] = 5'($urandom_range(0, 7));
        if_id.Curr_Instr[24:20] = 5'($urandom_range(0, 7));
        id_ex.Curr_Pc       = $urandom;
        id_ex.RD_One        = $urandom;
        id_ex.RD_Two        = $urandom;
        id_ex.Immediate     = $urandom;
        id_ex.RS_One        = 5'($urandom_range(0, 7));
        id_ex.RS_Two        = 5'($urandom_range(0, 7));
        id_ex.rd            = 5'($urandom_range(0, 7));
        id_ex.RegWrite      = 1'($urandom_range(0, 1));
        id_ex.MemRead       = 1'($urandom_range(0, 1));
        id_ex.MemWrite      = 1'($urandom_range(0, 1));
        id_ex.MemToReg      = 1'($urandom_range(0, 1));
        id_ex.HaltSignal    = ($urandom_range(0, 59) == 0);
        ex_mem.Alu_Result   = $urandom;
        ex_mem.RD_Two       = $urandom;
        ex_mem.rd           = 5'($urandom_range(0, 7));
        ex_mem.RegWrite     = 1'($urandom_range(0, 1));
        ex_mem.MemRead      = 1'($urandom_range(0, 1));
        ex_mem.MemWrite     = 1'($urandom_range(0, 1));
        ex_mem.MemToReg     = 1'($urandom_range(0, 1));
        mem_wb.Alu_Result   = $urandom;
        mem_wb.Mem_Data     = $urandom;
        mem_wb.rd           = 5'($urandom_range(0, 7));
        mem_wb.RegWrite     = 1'($urandom_range(0, 1));
        mem_wb.MemToReg     = 1'($urandom_range(0, 1));
        branch_taken        = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        clr();
        rst_n   = 1'b0;
        m_since = -1;
        m_stall = 0;
        m_flush = 0;
        @(posedge clk);
        #2;
        // Reset state with all-zero buffers
        do_reset();

        // Load-use stall for one cycle, then the bubble clears it
        clr();
        id_ex.MemRead    = 1'b1;
        id_ex.rd         = 5'd5;
        if_id.Curr_Instr = mk_instr(5'd5, 5'd0);
        step();
        clr();
        mem_wb.RegWrite  = 1'b1;
        mem_wb.rd        = 5'd5;
        id_ex.RS_One     = 5'd5;
        if_id.Curr_Instr = mk_instr(5'd5, 5'd0);
        step();

        // Forwarding priority: EX/MEM, then MEM/WB, then register file
        clr();
        ex_mem.RegWrite = 1'b1;
        ex_mem.rd       = 5'd7;
        mem_wb.RegWrite = 1'b1;
        mem_wb.rd       = 5'd7;
        id_ex.RS_One    = 5'd7;
        id_ex.RS_Two    = 5'd7;
        step();
        ex_mem.rd = 5'd0;
        step();
        mem_wb.rd = 5'd0;
        step();

        // Branch wins over a simultaneous load-use
        clr();
        id_ex.MemRead    = 1'b1;
        id_ex.rd         = 5'd3;
        if_id.Curr_Instr = mk_instr(5'd0, 5'd3);
        branch_taken     = 1'b1;
        step();
        clr();
        step();

        // Halt drain; a later branch must not disturb the frozen outputs
        id_ex.HaltSignal = 1'b1;
        step();
        clr();
        step();
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        step();
        step();

        // Reset mid-drain aborts to RUN and clears everything
        do_reset();
        clr();
        id_ex.HaltSignal = 1'b1;
        step();
        clr();
        do_reset();
        repeat (4) step();

        // Saturation of both counters
        clr();
        id_ex.MemRead    = 1'b1;
        id_ex.rd         = 5'd9;
        if_id.Curr_Instr = mk_instr(5'd1, 5'd9);
        repeat (20) step();
        branch_taken = 1'b1;
        repeat (20) step();

        // Random segments, each starting from reset
        for (int seg = 0; seg < 8; seg++) begin
            clr();
            do_reset();
            for (int c = 0; c < 40; c++) begin
                rand_inputs();
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
